addr_scan_controller: RTL and testbench

- Sequences the row/column counter inputs of the address generator (which computes S = row*ROW_PITCH + col) to raster-scan a rectangular tile of a feature map with a programmable stride.
- Issues one coordinate pair per cycle, subject to downstream credits, and delays a valid/last tag by the generator's fixed latency so the tag aligns with S.
- Sits between the layer sequencer (start/config) and the address generator → memory read-request FIFO.

---
 rtl/addr_scan_controller_pkg.sv | 23 ++
 rtl/addr_tag_delay.sv | 47 ++++
 rtl/addr_scan_controller.sv | 191 +++++++++++++++++++
 tb/tb_addr_scan_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_scan_controller_pkg.sv
// Shared types and defaults for the tile raster-scan controller and the
// address-generator wrapper that consumes its coordinates.
package addr_scan_controller_pkg;

  localparam int DEF_COORD_W  = 15;
  localparam int DEF_CNT_W    = 15;
  localparam int DEF_CREDITS  = 8;
  // Pipeline depth of the row*ROW_PITCH+col generator; the tag delay must match it.
  localparam int ADDR_GEN_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic vld;
    logic last;
  } addr_tag_t;

endpackage

// File: rtl/addr_tag_delay.sv
// Fixed-depth shift register carrying the {vld,last} tag alongside the
// address generator pipeline so the tag lands in the same cycle as S.
module addr_tag_delay
  import addr_scan_controller_pkg::*;
#(
  parameter int LAT = ADDR_GEN_LAT
) (
  input  logic      clk,
  input  logic      reset_n,
  input  addr_tag_t i_tag,
  output addr_tag_t o_tag,
  output logic      o_empty_next
);

  addr_tag_t r_stage [LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the stages are reset (unlike a data RAM) because a stale vld left
      // in the line would emit a phantom address after reset.
      for (int i = 0; i < LAT; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's
      // old value, which is what makes this a shift register rather than a wire.
      r_stage[0] <= i_tag;
      for (int i = 1; i < LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[LAT-1];

  // True when nothing sits behind the output stage: the line is empty once the
  // current output (if any) retires at the next edge.
  always_comb begin
    o_empty_next = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      if (r_stage[i].vld) begin
        o_empty_next = 1'b0;
      end
    end
  end

endmodule

// File: rtl/addr_scan_controller.sv
// Raster-scans a strided tile, presenting one row/col pair per cycle to the address
// generator when downstream credits allow, with a {vld,last} tag aligned to S.
module addr_scan_controller
  import addr_scan_controller_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int ADDR_LAT = ADDR_GEN_LAT,
  parameter int CREDITS  = DEF_CREDITS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] base_row,
  input  logic [COORD_W-1:0] base_col,
  input  logic [CNT_W-1:0]   tile_h,
  input  logic [CNT_W-1:0]   tile_w,
  input  logic [CNT_W-1:0]   stride,
  input  logic               credit_ret,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o,
  output logic               coord_vld,
  output logic               addr_vld,
  output logic               addr_last,
  output logic               busy,
  output logic               done
);

  localparam int                CRED_W   = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  scan_state_e r_state;
  scan_state_e w_state_nxt;

  logic [COORD_W-1:0] r_base_col;
  logic [CNT_W-1:0]   r_tile_h;
  logic [CNT_W-1:0]   r_tile_w;
  logic [CNT_W-1:0]   r_stride;

  // Next point to present (indices plus its running coordinates) and the last
  // point actually issued, which row_o/col_o show while stalled.
  logic [CNT_W-1:0]   r_h_idx;
  logic [CNT_W-1:0]   r_w_idx;
  logic [COORD_W-1:0] r_row_cur;
  logic [COORD_W-1:0] r_col_cur;
  logic [COORD_W-1:0] r_row_last;
  logic [COORD_W-1:0] r_col_last;

  logic [CRED_W-1:0]  r_credits;

  logic               w_start_ok;
  logic               w_issue;
  logic               w_w_end;
  logic               w_is_last;
  logic               w_tags_drained;
  logic [COORD_W-1:0] w_stride_c;
  addr_tag_t          w_tag_in;
  addr_tag_t          w_tag_out;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_w_end    = (r_w_idx == r_tile_w - CNT_ONE);
  assign w_is_last  = w_w_end && (r_h_idx == r_tile_h - CNT_ONE);
  assign w_stride_c = COORD_W'(r_stride);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    coord_vld   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (tile_h == '0 || tile_w == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (r_credits != '0) begin
          w_issue   = 1'b1;
          coord_vld = 1'b1;
          if (w_is_last) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_tags_drained) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- config
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base_col <= '0;
      r_tile_h   <= '0;
      r_tile_w   <= '0;
      r_stride   <= '0;
    end else if (w_start_ok) begin
      r_base_col <= base_col;
      r_tile_h   <= tile_h;
      r_tile_w   <= tile_w;
      r_stride   <= (stride == '0) ? CNT_ONE : stride;
    end
  end

  // ---------------------------------------------------------------- scan walk
  // Coordinates advance by adding the stride; they wrap modulo 2^COORD_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_idx    <= '0;
      r_w_idx    <= '0;
      r_row_cur  <= '0;
      r_col_cur  <= '0;
      r_row_last <= '0;
      r_col_last <= '0;
    end else if (w_start_ok) begin
      r_h_idx   <= '0;
      r_w_idx   <= '0;
      r_row_cur <= base_row;
      r_col_cur <= base_col;
    end else if (w_issue) begin
      r_row_last <= r_row_cur;
      r_col_last <= r_col_cur;
      if (w_w_end) begin
        r_w_idx   <= '0;
        r_h_idx   <= r_h_idx + CNT_ONE;
        r_col_cur <= r_base_col;
        r_row_cur <= r_row_cur + w_stride_c;
      end else begin
        r_w_idx   <= r_w_idx + CNT_ONE;
        r_col_cur <= r_col_cur + w_stride_c;
      end
    end
  end

  assign row_o = coord_vld ? r_row_cur : r_row_last;
  assign col_o = coord_vld ? r_col_cur : r_col_last;

  // ---------------------------------------------------------------- credits
  // Issue and return in the same cycle cancel; a return while full is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credits <= CRED_MAX;
    end else if (w_issue && !credit_ret) begin
      r_credits <= r_credits - CRED_ONE;
    end else if (!w_issue && credit_ret && (r_credits != CRED_MAX)) begin
      r_credits <= r_credits + CRED_ONE;
    end
  end

  // ---------------------------------------------------------------- tag delay
  assign w_tag_in.vld  = coord_vld;
  assign w_tag_in.last = coord_vld && w_is_last;

  addr_tag_delay #(
    .LAT (ADDR_LAT)
  ) u_tag_delay (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_tag        (w_tag_in),
    .o_tag        (w_tag_out),
    .o_empty_next (w_tags_drained)
  );

  assign addr_vld  = w_tag_out.vld;
  assign addr_last = w_tag_out.last;

endmodule

// File: tb/tb_addr_scan_controller.sv
// Scoreboard bench: stimulus pushes each tile's expected point list; a negedge
// monitor runs a cycle-level credit/latency model and compares every output.
module tb_addr_scan_controller;
  import addr_scan_controller_pkg::*;

  localparam int COORD_W = 15;
  localparam int CNT_W   = 15;
  localparam int LAT     = ADDR_GEN_LAT;
  localparam int CREDITS = 8;
  localparam int CMASK   = (1 << COORD_W) - 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [COORD_W-1:0] base_row = '0;
  logic [COORD_W-1:0] base_col = '0;
  logic [CNT_W-1:0]   tile_h = '0;
  logic [CNT_W-1:0]   tile_w = '0;
  logic [CNT_W-1:0]   stride = '0;
  logic               credit_ret = 1'b0;
  logic [COORD_W-1:0] row_o;
  logic [COORD_W-1:0] col_o;
  logic               coord_vld;
  logic               addr_vld;
  logic               addr_last;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  addr_scan_controller #(
    .COORD_W  (COORD_W),
    .ADDR_LAT (LAT),
    .CREDITS  (CREDITS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_row   (base_row),
    .base_col   (base_col),
    .tile_h     (tile_h),
    .tile_w     (tile_w),
    .stride     (stride),
    .credit_ret (credit_ret),
    .row_o      (row_o),
    .col_o      (col_o),
    .coord_vld  (coord_vld),
    .addr_vld   (addr_vld),
    .addr_last  (addr_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int row;
    int col;
    bit last;
  } pt_t;

  typedef struct {
    int due;
    bit last;
  } tag_t;

  pt_t  exp_pts[$];
  tag_t exp_tags[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int tiles_done = 0;
  int coords_seen = 0;
  bit ret_rand = 1'b0;

  // Reference model state (monitor-owned)
  int m_pend = 0;
  int m_credits = CREDITS;
  int m_done_due = -1;
  bit m_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Raster order of the tile, straight from base + index*stride modulo 2^COORD_W.
  task automatic push_tile(input int br, input int bc, input int h, input int w, input int s);
    int s0;
    pt_t p;
    s0 = (s == 0) ? 1 : s;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        p.row  = (br + r * s0) & CMASK;
        p.col  = (bc + c * s0) & CMASK;
        p.last = (r == h - 1) && (c == w - 1);
        exp_pts.push_back(p);
      end
    end
  endtask

  task automatic tick(input bit ret);
    @(posedge clk);
    #1;
    start      = 1'b0;
    credit_ret = ret_rand ? 1'($urandom_range(0, 1)) : ret;
  endtask

  task automatic start_tile(input int br, input int bc, input int h, input int w,
                            input int s, input bit accept);
    @(posedge clk);
    #1;
    base_row   = COORD_W'(br);
    base_col   = COORD_W'(bc);
    tile_h     = CNT_W'(h);
    tile_w     = CNT_W'(w);
    stride     = CNT_W'(s);
    start      = 1'b1;
    credit_ret = ret_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (accept) push_tile(br, bc, h, w, s);
    tick(1'b0);
    // Config must have been latched: scramble the inputs afterwards.
    base_row = COORD_W'($urandom);
    base_col = COORD_W'($urandom);
    tile_h   = CNT_W'($urandom);
    tile_w   = CNT_W'($urandom);
    stride   = CNT_W'($urandom);
  endtask

  task automatic wait_tiles(input int target, input string name);
    int n;
    n = 0;
    while (tiles_done < target && n < 600) begin
      tick(1'b0);
      n++;
    end
    check(name, 32'(tiles_done >= target), 32'd1);
  endtask

  task automatic refill();
    bit saved;
    saved    = ret_rand;
    ret_rand = 1'b0;
    repeat (CREDITS) tick(1'b1);
    tick(1'b0);
    ret_rand = saved;
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin : monitor
    bit   exp_vld;
    bit   exp_av;
    bit   exp_done;
    pt_t  p;
    tag_t t;
    cyc++;
    if (!reset_n) begin
      check("rst_row", 32'(row_o), 32'd0);
      check("rst_col", 32'(col_o), 32'd0);
      check("rst_flags", 32'({coord_vld, addr_vld, addr_last, busy, done}), 32'd0);
      exp_pts.delete();
      exp_tags.delete();
      m_pend     = 0;
      m_busy     = 1'b0;
      m_credits  = CREDITS;
      m_done_due = -1;
    end else begin
      exp_vld = (m_pend > 0) && (m_credits > 0);
      check("coord_vld", 32'(coord_vld), 32'(exp_vld));
      if (coord_vld) begin
        coords_seen++;
        check("coord_pending", 32'(exp_pts.size() > 0), 32'd1);
        if (exp_pts.size() > 0) begin
          p = exp_pts.pop_front();
          check("row_o", 32'(row_o), 32'(p.row));
          check("col_o", 32'(col_o), 32'(p.col));
          t.due  = cyc + LAT;
          t.last = p.last;
          exp_tags.push_back(t);
          if (p.last) m_done_due = cyc + LAT + 1;
        end
      end

      exp_av = (exp_tags.size() > 0) && (exp_tags[0].due == cyc);
      check("addr_vld", 32'(addr_vld), 32'(exp_av));
      if (exp_av) begin
        t = exp_tags.pop_front();
        check("addr_last", 32'(addr_last), 32'(t.last));
      end

      exp_done = (m_done_due == cyc);
      check("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        tiles_done++;
        m_busy     = 1'b0;
        m_done_due = -1;
      end
      check("busy", 32'(busy), 32'(m_busy));

      if (exp_vld) m_pend--;
      if (exp_vld && !credit_ret) m_credits--;
      else if (!exp_vld && credit_ret && m_credits < CREDITS) m_credits++;

      if (start && !m_busy && !exp_done) begin
        if (tile_h == '0 || tile_w == '0) begin
          m_done_due = cyc + 1;
        end else begin
          m_busy = 1'b1;
          m_pend = tile_h * tile_w;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : stim
    int c0;
    int t0;
    int h;
    int w;
    int s;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick(1'b0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Basic 2x3 tile, stride 1
    ret_rand = 1'b1;
    start_tile(10, 20, 2, 3, 1, 1'b1);
    wait_tiles(1, "tile_2x3_done");

    // Stride 4, then stride 0 treated as 1
    start_tile(0, 0, 2, 2, 4, 1'b1);
    wait_tiles(2, "tile_s4_done");
    start_tile(0, 0, 2, 2, 0, 1'b1);
    wait_tiles(3, "tile_s0_done");

    // Credit starvation: no returns until the pool runs dry
    ret_rand = 1'b0;
    refill();
    c0 = coords_seen;
    start_tile(0, 0, 2, 6, 1, 1'b1);
    repeat (12) tick(1'b0);
    check("stall_count", 32'(coords_seen - c0), 32'(CREDITS));
    tick(1'b1);
    repeat (3) tick(1'b0);
    check("one_ret_one_issue", 32'(coords_seen - c0), 32'(CREDITS + 1));
    tick(1'b1);
    tick(1'b1);
    repeat (3) tick(1'b0);
    check("ret_with_issue", 32'(coords_seen - c0), 32'(CREDITS + 3));
    tick(1'b1);
    wait_tiles(4, "tile_starve_done");
    check("starve_total", 32'(coords_seen - c0), 32'd12);
    refill();

    // Empty tiles finish one cycle after start without points
    ret_rand = 1'b1;
    c0 = coords_seen;
    t0 = tiles_done;
    start_tile(5, 5, 3, 0, 2, 1'b1);
    tick(1'b0);
    check("empty_w_done", 32'(tiles_done), 32'(t0 + 1));
    start_tile(5, 5, 0, 4, 2, 1'b1);
    tick(1'b0);
    check("empty_h_done", 32'(tiles_done), 32'(t0 + 2));
    check("empty_no_pts", 32'(coords_seen), 32'(c0));

    // Start while busy is ignored
    c0 = coords_seen;
    t0 = tiles_done;
    start_tile(100, 200, 3, 3, 2, 1'b1);
    tick(1'b0);
    start_tile(7, 7, 4, 4, 1, 1'b0);
    wait_tiles(t0 + 1, "busy_start_done");
    repeat (6) tick(1'b0);
    check("busy_start_tiles", 32'(tiles_done), 32'(t0 + 1));
    check("busy_start_pts", 32'(coords_seen - c0), 32'd9);

    // Column wrap
    start_tile(0, 32766, 1, 3, 1, 1'b1);
    wait_tiles(t0 + 2, "wrap_done");

    // Random tiles
    for (int k = 0; k < 40; k++) begin
      h = $urandom_range(0, 5);
      w = $urandom_range(0, 5);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32767) : $urandom_range(0, 3);
      t0 = tiles_done;
      start_tile($urandom_range(0, CMASK), $urandom_range(0, CMASK), h, w, s, 1'b1);
      wait_tiles(t0 + 1, "rand_done");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick(1'b0);
    end

    // Reset in the middle of a 4x4 scan
    t0 = tiles_done;
    start_tile(1, 2, 4, 4, 1, 1'b1);
    repeat (5) tick(1'b0);
    @(posedge clk);
    #1;
    credit_ret = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("abort_row", 32'(row_o), 32'd0);
    check("abort_col", 32'(col_o), 32'd0);
    check("abort_flags", 32'({coord_vld, addr_vld, addr_last, busy, done}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) tick(1'b0);
    check("abort_no_done", 32'(tiles_done), 32'(t0));

    // Credits are back at CREDITS after reset
    ret_rand = 1'b0;
    c0 = coords_seen;
    start_tile(3, 4, 4, 4, 1, 1'b1);
    repeat (12) tick(1'b0);
    check("post_rst_credits", 32'(coords_seen - c0), 32'(CREDITS));
    ret_rand = 1'b1;
    wait_tiles(t0 + 1, "post_rst_done");
    check("post_rst_pts", 32'(coords_seen - c0), 32'd16);

    repeat (4) tick(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
